// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: parameter defaults,
// FSM state encoding and a small index helper.
package com_bus_arbiter_pkg;

   // Default sizing: 4 I-cache + 4 D-cache requesters on the common bus
   localparam int unsigned NUM_REQ_DEF    = 8;
   localparam int unsigned MAX_TENURE_DEF = 16;
   localparam int unsigned ID_W_DEF       = 3;

   // Tenure counter width covers the full legal MAX_TENURE range (2..255)
   localparam int unsigned CNT_W          = 8;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   // Increment an index modulo n (n need not be a power of two)
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage : com_bus_arbiter_pkg

// File: rtl/com_bus_arbiter_if.sv
// Common-bus request/grant bundle between the cache wrappers and the arbiter.
interface com_bus_arbiter_if
   import com_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ID_W    = ID_W_DEF
);

   logic [NUM_REQ-1:0] Com_Bus_Req;
   logic [NUM_REQ-1:0] Com_Bus_Gnt;
   logic [ID_W-1:0]    Gnt_id;
   logic               Bus_busy;
   logic               Tenure_expired;

   // Requester side: drives requests, observes grant status
   modport master (
      output Com_Bus_Req,
      input  Com_Bus_Gnt,
      input  Gnt_id,
      input  Bus_busy,
      input  Tenure_expired
   );

   // Arbiter side: observes requests, drives grant status
   modport slave (
      input  Com_Bus_Req,
      output Com_Bus_Gnt,
      output Gnt_id,
      output Bus_busy,
      output Tenure_expired
   );

endinterface : com_bus_arbiter_if

// File: rtl/com_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping
// from NUM_REQ-1 back to 0. Purely combinational.
module rr_priority_picker
   import com_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ID_W    = ID_W_DEF
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid_c,
   output logic [ID_W-1:0]    winner_c
);

   // Scan NUM_REQ positions starting at ptr; the first hit wins
   always_comb begin
      int unsigned idx;
      valid_c  = 1'b0;
      winner_c = '0;
      idx      = 32'd0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!valid_c && req[ID_W'(idx)]) begin
            valid_c  = 1'b1;
            winner_c = ID_W'(idx);
         end
      end
   end

endmodule : rr_priority_picker

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin grant of the shared address/data bus to
// one of NUM_REQ cache requesters, with bounded tenure and a one-cycle
// turnaround between owners.
module com_bus_arbiter
   import com_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned MAX_TENURE = MAX_TENURE_DEF,
   parameter int unsigned ID_W       = ID_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   com_bus_arbiter_if.slave bus
);

   // Counter value of the last permitted grant cycle in a tenure
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TENURE - 1);

   arb_state_e         state_q,   state_d;
   logic [NUM_REQ-1:0] gnt_q,     gnt_d;
   logic [ID_W-1:0]    gnt_id_q,  gnt_id_d;
   logic [ID_W-1:0]    ptr_q,     ptr_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               busy_q,    busy_d;
   logic               expired_q, expired_d;

   logic               pick_valid_c;
   logic [ID_W-1:0]    pick_winner_c;
   logic               owner_req_c;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req      (bus.Com_Bus_Req),
      .ptr      (ptr_q),
      .valid_c  (pick_valid_c),
      .winner_c (pick_winner_c)
   );

   // Current grantee's request level; only meaningful in GRANT
   assign owner_req_c = bus.Com_Bus_Req[gnt_id_q];

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      expired_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               state_d  = ST_GRANT;
               gnt_d    = NUM_REQ'(1) << pick_winner_c;
               gnt_id_d = pick_winner_c;
               ptr_d    = ID_W'(wrap_inc(32'(pick_winner_c), NUM_REQ));
               cnt_d    = '0;
               busy_d   = 1'b1;
            end
         end

         ST_GRANT: begin
            // Voluntary release, or forced release on the final tenure cycle
            if (!owner_req_c || (cnt_q == CNT_LAST)) begin
               state_d   = ST_RELEASE;
               gnt_d     = '0;
               gnt_id_d  = '0;
               cnt_d     = '0;
               expired_d = owner_req_c;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            // Single turnaround cycle for the tri-stated bus
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
      end
   end

   assign bus.Com_Bus_Gnt    = gnt_q;
   assign bus.Gnt_id         = gnt_id_q;
   assign bus.Bus_busy       = busy_q;
   assign bus.Tenure_expired = expired_q;

endmodule : com_bus_arbiter

// File: tb/tb_com_bus_arbiter.sv
// Self-checking bench for com_bus_arbiter: directed scenarios plus random
// request traffic, all compared against a behavioural bus-ownership model.
module tb_com_bus_arbiter;

   localparam int unsigned NUM_REQ    = 8;
   localparam int unsigned MAX_TENURE = 16;
   localparam int unsigned ID_W       = 3;
   localparam int unsigned WAIT_BOUND = (NUM_REQ - 1) * (MAX_TENURE + 2) + 1;

   logic clk;
   logic rst_n;

   com_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   com_bus_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .MAX_TENURE (MAX_TENURE),
      .ID_W       (ID_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks;
   int n_errors;

   // Ownership model: who holds the bus, for how long, turnaround left
   int m_owner;
   int m_held;
   int m_gap;
   int m_rr;
   bit m_te;

   // Requester agents
   bit pend [NUM_REQ];
   int want [NUM_REQ];
   int got  [NUM_REQ];

   // Observation records
   int               wt     [NUM_REQ];
   int               max_wt [NUM_REQ];
   bit               own    [NUM_REQ];
   logic [NUM_REQ-1:0] prev_g;
   int               ord [$];
   bit               g0_hist [$];
   bit               te_hist [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_gap   = 0;
      m_rr    = 0;
      m_te    = 1'b0;
   endtask

   // Advance the model across one rising edge given the request vector seen there
   task automatic model_step(input logic [NUM_REQ-1:0] r);
      m_te = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_gap   = 1;
         end else if (m_held == int'(MAX_TENURE) - 1) begin
            m_owner = -1;
            m_gap   = 1;
            m_te    = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (r != '0) begin
         for (int k = 0; k < int'(NUM_REQ); k++) begin
            int c;
            c = (m_rr + k) % int'(NUM_REQ);
            if (r[c]) begin
               m_owner = c;
               break;
            end
         end
         m_rr   = (m_owner + 1) % int'(NUM_REQ);
         m_held = 0;
      end
   endtask

   task automatic clear_mon();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         wt[i]     = 0;
         max_wt[i] = 0;
         own[i]    = 1'b0;
      end
      prev_g = '0;
      ord.delete();
      g0_hist.delete();
      te_hist.delete();
   endtask

   task automatic clear_stim();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         pend[i] = 1'b0;
         want[i] = 0;
         got[i]  = 0;
      end
   endtask

   // One cycle: check outputs at negedge, record, then drive next request
   task automatic tick(input logic [NUM_REQ-1:0] r);
      logic [NUM_REQ-1:0] g;
      logic [NUM_REQ-1:0] cur;
      logic [NUM_REQ-1:0] eg;
      @(negedge clk);
      g   = bus.Com_Bus_Gnt;
      cur = bus.Com_Bus_Req;
      eg  = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check_eq("gnt", 32'(g), 32'(eg));
      check_eq("gnt_id", 32'(bus.Gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check_eq("busy", 32'(bus.Bus_busy), 32'((m_owner >= 0) || (m_gap > 0)));
      check_eq("expired", 32'(bus.Tenure_expired), 32'(m_te));
      check_eq("onehot", 32'($countones(g) <= 1), 32'd1);
      if ((g != '0) && (prev_g == '0)) ord.push_back(int'(bus.Gnt_id));
      prev_g = g;
      g0_hist.push_back(g[0]);
      te_hist.push_back(bus.Tenure_expired);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (g[i]) begin
            own[i] = 1'b1;
            wt[i]  = 0;
         end else begin
            if (!bus.Bus_busy) own[i] = 1'b0;
            if (!cur[i]) begin
               wt[i] = 0;
            end else if (!own[i]) begin
               wt[i]++;
               if (wt[i] > max_wt[i]) max_wt[i] = wt[i];
            end
         end
      end
      bus.Com_Bus_Req = r;
      model_step(r);
   endtask

   // Agents hold a request until they have had 'want' grant cycles (0 = forever)
   task automatic run(input int n, input int rate, input int want_fix, input logic [NUM_REQ-1:0] mask);
      for (int c = 0; c < n; c++) begin
         logic [NUM_REQ-1:0] r;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (m_owner == i) got[i]++;
            if (pend[i] && (want[i] != 0) && (got[i] >= want[i])) begin
               pend[i] = 1'b0;
            end else if (!pend[i] && mask[i] && ($urandom_range(rate - 1) == 0)) begin
               pend[i] = 1'b1;
               got[i]  = 0;
               want[i] = (want_fix > 0) ? want_fix : int'($urandom_range(24, 1));
            end
            r[i] = pend[i];
         end
         tick(r);
      end
   endtask

   task automatic do_reset(input logic [NUM_REQ-1:0] r0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.Com_Bus_Req = r0;
      model_reset();
      clear_mon();
      @(posedge clk);
      #1;
      check_eq("rst_gnt", 32'(bus.Com_Bus_Gnt), 32'd0);
      check_eq("rst_id", 32'(bus.Gnt_id), 32'd0);
      check_eq("rst_busy", 32'(bus.Bus_busy), 32'd0);
      check_eq("rst_expired", 32'(bus.Tenure_expired), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_step(r0);
   endtask

   initial begin
      int s;
      int len;
      int gap;
      int te_cnt;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.Com_Bus_Req = '0;
      clear_stim();
      model_reset();
      clear_mon();

      // Single request from idle: one-cycle latency to grant
      do_reset('0);
      tick(8'h00);
      tick(8'h08);
      tick(8'h08);
      check_eq("r29_gnt", 32'(bus.Com_Bus_Gnt), 32'h08);
      check_eq("r29_id", 32'(bus.Gnt_id), 32'd3);
      check_eq("r29_busy", 32'(bus.Bus_busy), 32'd1);
      tick(8'h00);
      tick(8'h00);
      tick(8'h00);

      // All requesting, 3-cycle tenures: strict rotation 0..7,0
      clear_stim();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         pend[i] = 1'b1;
         want[i] = 3;
      end
      do_reset(8'hFF);
      run(50, 1, 3, 8'hFF);
      check_eq("r30_count", 32'(ord.size() >= 9), 32'd1);
      for (int k = 0; k < 9; k++) begin
         check_eq("r30_order", (k < ord.size()) ? 32'(ord[k]) : 32'hFFFF_FFFF, 32'(k % 8));
      end

      // Single requester held forever: forced release after MAX_TENURE
      clear_stim();
      pend[0] = 1'b1;
      do_reset(8'h01);
      run(40, 1, 0, 8'h00);
      s = 0;
      while ((s < g0_hist.size()) && !g0_hist[s]) s++;
      len = 0;
      while ((s + len < g0_hist.size()) && g0_hist[s + len]) len++;
      gap = 0;
      while ((s + len + gap < g0_hist.size()) && !g0_hist[s + len + gap]) gap++;
      te_cnt = 0;
      for (int k = 0; (k < s + len + gap) && (k < te_hist.size()); k++) te_cnt += int'(te_hist[k]);
      check_eq("r31_len", 32'(len), 32'(MAX_TENURE));
      check_eq("r31_gap", 32'(gap), 32'd2);
      check_eq("r31_te_cnt", 32'(te_cnt), 32'd1);
      check_eq("r31_te_pos", (s + len < te_hist.size()) ? 32'(te_hist[s + len]) : 32'd0, 32'd1);

      // Late requester beats the expired holder on the next arbitration
      clear_stim();
      pend[2] = 1'b1;
      do_reset(8'h04);
      run(6, 1, 0, 8'h00);
      pend[5] = 1'b1;
      want[5] = 3;
      got[5]  = 0;
      run(40, 1, 0, 8'h00);
      check_eq("r32_count", 32'(ord.size() >= 3), 32'd1);
      check_eq("r32_first", (ord.size() > 0) ? 32'(ord[0]) : 32'hFFFF_FFFF, 32'd2);
      check_eq("r32_second", (ord.size() > 1) ? 32'(ord[1]) : 32'hFFFF_FFFF, 32'd5);
      check_eq("r32_third", (ord.size() > 2) ? 32'(ord[2]) : 32'hFFFF_FFFF, 32'd2);

      // Asynchronous reset in mid-tenure, then re-arbitration
      clear_stim();
      pend[6] = 1'b1;
      do_reset(8'h40);
      run(5, 1, 0, 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("r33_async_gnt", 32'(bus.Com_Bus_Gnt), 32'd0);
      check_eq("r33_async_id", 32'(bus.Gnt_id), 32'd0);
      check_eq("r33_async_busy", 32'(bus.Bus_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      clear_mon();
      model_step(bus.Com_Bus_Req);
      run(3, 1, 0, 8'h00);
      check_eq("r33_regrant", (ord.size() > 0) ? 32'(ord[0]) : 32'hFFFF_FFFF, 32'd6);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         pend[i] = 1'b1;
         want[i] = 2;
         got[i]  = 0;
      end
      run(20, 1, 0, 8'h00);
      check_eq("r33_next", (ord.size() > 1) ? 32'(ord[1]) : 32'hFFFF_FFFF, 32'd7);

      // Random traffic with wait-bound tracking
      clear_stim();
      do_reset('0);
      run(10000, 6, 0, 8'hFF);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         check_eq("wait_bound", 32'(max_wt[i] <= int'(WAIT_BOUND)), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_com_bus_arbiter
